// File: rtl/rab_w_arb_pkg.sv
// ----------------------------------------------------------------------------
// rab_w_arb_pkg
// Shared types and constants for the AXI4 W-channel order arbiter.
//   order_entry_t    : one order-FIFO entry {len, port}
//   LEN_WIDTH        : AWLEN width
//   PORT_FIELD_WIDTH : room reserved for the port index inside an entry
//   cnt_width()      : width of an occupancy counter able to hold 0..depth
// ----------------------------------------------------------------------------
package rab_w_arb_pkg;

    localparam int LEN_WIDTH        = 8;
    localparam int PORT_FIELD_WIDTH = 8;

    typedef struct packed {
        logic [LEN_WIDTH-1:0]        len;
        logic [PORT_FIELD_WIDTH-1:0] port;
    } order_entry_t;

    localparam int ORDER_ENTRY_WIDTH = $bits(order_entry_t);

    // Occupancy counters must represent "full" (== depth), hence the extra bit.
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rab_order_fifo.sv
// ----------------------------------------------------------------------------
// rab_order_fifo
// Synchronous FIFO holding the order in which W bursts must be served.
// Head is read combinationally from the registered read pointer, so an entry
// pushed into an empty FIFO becomes visible the cycle after the push.
// A push while full is only accepted when a pop happens in the same cycle.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   push/push_data write request and entry
//   pop            remove head (ignored when empty)
//   head           current head entry
//   count          occupancy 0..DEPTH
//   full, empty    occupancy flags (from registered count only)
// ----------------------------------------------------------------------------
module rab_order_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign pop_ok_s  = pop & ~empty;
    // When full, the slot being popped is the one written, so push is safe.
    assign push_ok_s = push & (~full | pop_ok_s);
    assign head      = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Entry storage; needs no reset because empty gates every use of head.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/axi4_w_order_arbiter.sv
// ----------------------------------------------------------------------------
// axi4_w_order_arbiter
// Shares one master AXI4 W channel among NUM_PORTS W senders. AXI4 has no
// WID, so every master AW handshake pushes its owning port into an order
// FIFO and the W mux serves bursts strictly in FIFO order.
// Ports:
//   axi4_aclk, axi4_arst          clock, synchronous active-high reset
//   aw_push_valid/port/len        master AW handshake and its owner / AWLEN
//   aw_stall                      order FIFO full, AW arbiter must not grant
//   s_axi4_w*                     packed per-port W channels (port i = slice i)
//   m_axi4_w*                     master W channel
//   pending_cnt                   order FIFO occupancy
//   order_ovf                     sticky: push dropped because FIFO was full
//   len_err                       (RAB_W_LEN_CHECK_EN only) one-cycle pulse
//                                 when a burst's beat count disagrees with AWLEN
// Optional feature macro: RAB_W_LEN_CHECK_EN
// ----------------------------------------------------------------------------
module axi4_w_order_arbiter
    import rab_w_arb_pkg::*;
#(
    parameter int NUM_PORTS      = 4,
    parameter int LOG_NUM_PORTS  = 2,
    parameter int ORDER_DEPTH    = 8,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_USER_WIDTH = 2
) (
    input  logic                                   axi4_aclk,
    input  logic                                   axi4_arst,
    input  logic                                   aw_push_valid,
    input  logic [LOG_NUM_PORTS-1:0]               aw_push_port,
    input  logic [LEN_WIDTH-1:0]                   aw_push_len,
    output logic                                   aw_stall,
    input  logic [NUM_PORTS*AXI_DATA_WIDTH-1:0]    s_axi4_wdata,
    input  logic [NUM_PORTS*AXI_DATA_WIDTH/8-1:0]  s_axi4_wstrb,
    input  logic [NUM_PORTS*AXI_USER_WIDTH-1:0]    s_axi4_wuser,
    input  logic [NUM_PORTS-1:0]                   s_axi4_wlast,
    input  logic [NUM_PORTS-1:0]                   s_axi4_wvalid,
    output logic [NUM_PORTS-1:0]                   s_axi4_wready,
    output logic [AXI_DATA_WIDTH-1:0]              m_axi4_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]            m_axi4_wstrb,
    output logic [AXI_USER_WIDTH-1:0]              m_axi4_wuser,
    output logic                                   m_axi4_wlast,
    output logic                                   m_axi4_wvalid,
    input  logic                                   m_axi4_wready,
`ifdef RAB_W_LEN_CHECK_EN
    output logic                                   len_err,
`endif
    output logic [cnt_width(ORDER_DEPTH)-1:0]      pending_cnt,
    output logic                                   order_ovf
);

    localparam int STRB_W = AXI_DATA_WIDTH / 8;

    order_entry_t               push_entry_s;
    order_entry_t               head_s;
    logic                       fifo_full_s;
    logic                       fifo_empty_s;
    logic                       hv_s;
    logic [LOG_NUM_PORTS-1:0]   sel_s;
    logic                       w_hs_s;
    logic                       pop_s;
    logic                       order_ovf_r;
    logic                       unused_head_s;

    assign push_entry_s = '{len: aw_push_len, port: PORT_FIELD_WIDTH'(aw_push_port)};

    rab_order_fifo #(
        .WIDTH (ORDER_ENTRY_WIDTH),
        .DEPTH (ORDER_DEPTH)
    ) u_order_fifo (
        .clk       (axi4_aclk),
        .rst       (axi4_arst),
        .push      (aw_push_valid),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .head      (head_s),
        .count     (pending_cnt),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    assign hv_s          = ~fifo_empty_s;
    assign sel_s         = head_s.port[LOG_NUM_PORTS-1:0];
    assign unused_head_s = ^head_s;
    assign aw_stall      = fifo_full_s;
    assign order_ovf     = order_ovf_r;
    assign w_hs_s        = m_axi4_wvalid & m_axi4_wready;
    assign pop_s         = w_hs_s & m_axi4_wlast;

    // W mux: only the FIFO head port is visible; m_axi4_wready reaches only wready.
    always_comb begin
        m_axi4_wdata  = {AXI_DATA_WIDTH{1'b0}};
        m_axi4_wstrb  = {STRB_W{1'b0}};
        m_axi4_wuser  = {AXI_USER_WIDTH{1'b0}};
        m_axi4_wlast  = 1'b0;
        m_axi4_wvalid = 1'b0;
        s_axi4_wready = {NUM_PORTS{1'b0}};
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (hv_s && (sel_s == i[LOG_NUM_PORTS-1:0])) begin
                m_axi4_wdata     = s_axi4_wdata[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
                m_axi4_wstrb     = s_axi4_wstrb[i*STRB_W +: STRB_W];
                m_axi4_wuser     = s_axi4_wuser[i*AXI_USER_WIDTH +: AXI_USER_WIDTH];
                m_axi4_wlast     = s_axi4_wlast[i];
                m_axi4_wvalid    = s_axi4_wvalid[i];
                s_axi4_wready[i] = m_axi4_wready;
            end else begin
                s_axi4_wready[i] = 1'b0;
            end
        end
    end

    // Sticky overflow: a push was lost because the FIFO was full and nothing popped.
    always_ff @(posedge axi4_aclk) begin
        if (axi4_arst) begin
            order_ovf_r <= 1'b0;
        end else if (aw_push_valid && fifo_full_s && !pop_s) begin
            order_ovf_r <= 1'b1;
        end else begin
            order_ovf_r <= order_ovf_r;
        end
    end

`ifdef RAB_W_LEN_CHECK_EN
    logic [LEN_WIDTH-1:0] beat_cnt_r;
    logic                 len_err_r;

    assign len_err = len_err_r;

    // Beat counter per burst; flags wlast that disagrees with the head's AWLEN.
    always_ff @(posedge axi4_aclk) begin
        if (axi4_arst) begin
            beat_cnt_r <= {LEN_WIDTH{1'b0}};
            len_err_r  <= 1'b0;
        end else if (w_hs_s) begin
            len_err_r  <= m_axi4_wlast ^ (beat_cnt_r == head_s.len);
            if (m_axi4_wlast) begin
                beat_cnt_r <= {LEN_WIDTH{1'b0}};
            end else begin
                beat_cnt_r <= beat_cnt_r + LEN_WIDTH'(1);
            end
        end else begin
            len_err_r  <= 1'b0;
            beat_cnt_r <= beat_cnt_r;
        end
    end
`endif

endmodule
